pipe_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the stall[5:0] bus used by all pipeline registers, including the ID/EX register.
- Sequences branch-mispredict flushes and defers a flush while EX/MEM are frozen.
- Masks stale ID requests after a flush and watches for runaway stalls.

---
 rtl/pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl                                              |
// | Description : Central stall/flush scheduler for the 6-stage pipeline       |
// |               (PC, IF, ID, EX, MEM, WB). Merges per-stage stall requests   |
// |               into a priority-encoded stall bus, sequences mispredict      |
// |               flushes (deferring them while EX/MEM are frozen), masks      |
// |               stale ID requests after a flush and runs a stall watchdog.   |
// | Ports       : clk, rst (async, active-low)                                  |
// |               stallreq_if/id/ex/mem    per-stage hold requests             |
// |               ex_mispredict, ex_redirect_pc  branch resolution from EX     |
// |               stall[5:0]  bit0 PC .. bit5 WB, 1 = stop                     |
// |               flush, new_pc  kill IF/ID + ID/EX, load new_pc              |
// |               ctrl_state  FSM state (debug)                                |
// |               stall_timeout  one-cycle watchdog pulse                      |
// | Option      : HAZARD_PERF_EN adds perf_stall_cycles, perf_flushes and     |
// |               perf_deferred event counters (PERF_WIDTH = 32).              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
   parameter int PC_WIDTH      = 32,
   parameter int STALL_TIMEOUT = 64,
   parameter int CNT_WIDTH     = 8
`ifdef HAZARD_PERF_EN
   ,
   localparam int PERF_WIDTH   = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallreq_if,
   input  logic                  stallreq_id,
   input  logic                  stallreq_ex,
   input  logic                  stallreq_mem,
   input  logic                  ex_mispredict,
   input  logic [PC_WIDTH-1:0]   ex_redirect_pc,
   output logic [5:0]            stall,
   output logic                  flush,
   output logic [PC_WIDTH-1:0]   new_pc,
   output logic [1:0]            ctrl_state,
   output logic                  stall_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_WIDTH-1:0] perf_stall_cycles,
   output logic [PERF_WIDTH-1:0] perf_flushes,
   output logic [PERF_WIDTH-1:0] perf_deferred
`endif
);

   typedef enum logic [1:0] {
      S_RUN        = 2'd0,
      S_STALL      = 2'd1,
      S_FLUSH_PEND = 2'd2,
      S_RECOVER    = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_cnt_max    = {CNT_WIDTH{1'b1}};
   // The pulse is scheduled on the edge where the counter becomes
   // STALL_TIMEOUT, so it is visible during the following cycle.
   localparam logic [CNT_WIDTH-1:0] c_timeout_m1 = CNT_WIDTH'(STALL_TIMEOUT - 1);

   state_t                r_state;
   state_t                w_state_next;
   logic [PC_WIDTH-1:0]   r_pend_pc;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_timeout;

   logic                  w_blocked;
   logic                  w_id_req;
   logic [5:0]            w_stall_enc;
   logic [5:0]            w_stall;
   logic                  w_flush;
   logic [PC_WIDTH-1:0]   w_new_pc;
   logic                  w_latch_pend;
   logic                  w_stall_any;

   assign w_blocked = stallreq_mem | stallreq_ex;
   // The instruction in ID during RECOVER is the one just flushed, so its
   // load-use request is stale.
   assign w_id_req  = stallreq_id & (r_state != S_RECOVER);

   // Highest requesting stage wins; every upstream stage stops with it.
   always_comb begin
      w_stall_enc = 6'b000000;
      if (stallreq_mem)
         w_stall_enc = 6'b011111;
      else if (stallreq_ex)
         w_stall_enc = 6'b001111;
      else if (w_id_req)
         w_stall_enc = 6'b000111;
      else if (stallreq_if)
         w_stall_enc = 6'b000011;
   end

   always_comb begin
      w_stall      = w_stall_enc;
      w_flush      = 1'b0;
      w_new_pc     = '0;
      w_latch_pend = 1'b0;
      w_state_next = r_state;

      case (r_state)
         S_FLUSH_PEND: begin
            // New mispredicts are ignored: the older branch owns the flush.
            if (!w_blocked) begin
               w_flush      = 1'b1;
               w_new_pc     = r_pend_pc;
               w_stall      = 6'b000000;
               w_state_next = S_RECOVER;
            end
         end
         default: begin
            if (ex_mispredict && !w_blocked) begin
               // IF/ID requests belong to wrong-path instructions being killed.
               w_flush      = 1'b1;
               w_new_pc     = ex_redirect_pc;
               w_stall      = 6'b000000;
               w_state_next = S_RECOVER;
            end else if (ex_mispredict) begin
               w_latch_pend = 1'b1;
               w_state_next = S_FLUSH_PEND;
            end else if (w_stall_enc != 6'b000000) begin
               w_state_next = S_STALL;
            end else begin
               w_state_next = S_RUN;
            end
         end
      endcase
   end

   // Outputs are held quiet for the whole time reset is asserted, not just
   // after the next edge.
   assign stall         = rst ? w_stall  : 6'b000000;
   assign flush         = rst ? w_flush  : 1'b0;
   assign new_pc        = rst ? w_new_pc : '0;
   assign ctrl_state    = r_state;
   assign stall_timeout = r_timeout;

   assign w_stall_any   = (stall != 6'b000000);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_RUN;
         r_pend_pc <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_latch_pend)
            r_pend_pc <= ex_redirect_pc;
      end
   end

   // Stall-run watchdog. The counter only moves upward within a run, so
   // passing STALL_TIMEOUT-1 happens at most once before it clears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_stall_any) begin
            if (r_cnt != c_cnt_max)
               r_cnt <= r_cnt + CNT_WIDTH'(1);
            r_timeout <= (r_cnt == c_timeout_m1);
         end else begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic w_enter_pend;

   assign w_enter_pend = (w_state_next == S_FLUSH_PEND) && (r_state != S_FLUSH_PEND);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cycles <= '0;
         perf_flushes      <= '0;
         perf_deferred     <= '0;
      end else begin
         if (w_stall_any)
            perf_stall_cycles <= perf_stall_cycles + PERF_WIDTH'(1);
         if (flush)
            perf_flushes <= perf_flushes + PERF_WIDTH'(1);
         if (w_enter_pend)
            perf_deferred <= perf_deferred + PERF_WIDTH'(1);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_hazard_ctrl                                           |
// | Description : Directed table-driven bench for pipe_hazard_ctrl with        |
// |               hand-written sequences for watchdog and async reset.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

   localparam int PC_WIDTH = 32;

   logic                clk;
   logic                rst;
   logic                stallreq_if;
   logic                stallreq_id;
   logic                stallreq_ex;
   logic                stallreq_mem;
   logic                ex_mispredict;
   logic [PC_WIDTH-1:0] ex_redirect_pc;
   logic [5:0]          stall;
   logic                flush;
   logic [PC_WIDTH-1:0] new_pc;
   logic [1:0]          ctrl_state;
   logic                stall_timeout;
`ifdef HAZARD_PERF_EN
   logic [31:0]         perf_stall_cycles;
   logic [31:0]         perf_flushes;
   logic [31:0]         perf_deferred;
`endif

   int total;
   int bad;

   pipe_hazard_ctrl #(
      .PC_WIDTH      (PC_WIDTH),
      .STALL_TIMEOUT (4),
      .CNT_WIDTH     (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stallreq_if    (stallreq_if),
      .stallreq_id    (stallreq_id),
      .stallreq_ex    (stallreq_ex),
      .stallreq_mem   (stallreq_mem),
      .ex_mispredict  (ex_mispredict),
      .ex_redirect_pc (ex_redirect_pc),
      .stall          (stall),
      .flush          (flush),
      .new_pc         (new_pc),
      .ctrl_state     (ctrl_state),
      .stall_timeout  (stall_timeout)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flushes      (perf_flushes),
      .perf_deferred     (perf_deferred)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // req = {mem, ex, id, if}; cs is the state during the row's cycle.
   typedef struct {
      logic [3:0]  req;
      logic        mis;
      logic [31:0] pc;
      logic [5:0]  st;
      logic        fl;
      logic [31:0] npc;
      logic [1:0]  cs;
      logic        to;
   } vec_t;

   vec_t tbl [25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic mis, input logic [31:0] pc);
      stallreq_mem   = req[3];
      stallreq_ex    = req[2];
      stallreq_id    = req[1];
      stallreq_if    = req[0];
      ex_mispredict  = mis;
      ex_redirect_pc = pc;
   endtask

   initial begin
      int pulses;
      total = 0;
      bad   = 0;

      tbl[0]  = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd0, 1'b0};
      tbl[1]  = '{4'b0010, 1'b0, 32'h0,   6'b000111, 1'b0, 32'h0,   2'd0, 1'b0};
      tbl[2]  = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd1, 1'b0};
      tbl[3]  = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd0, 1'b0};
      tbl[4]  = '{4'b0001, 1'b0, 32'h0,   6'b000011, 1'b0, 32'h0,   2'd0, 1'b0};
      tbl[5]  = '{4'b0011, 1'b0, 32'h0,   6'b000111, 1'b0, 32'h0,   2'd1, 1'b0};
      tbl[6]  = '{4'b0110, 1'b0, 32'h0,   6'b001111, 1'b0, 32'h0,   2'd1, 1'b0};
      tbl[7]  = '{4'b1001, 1'b0, 32'h0,   6'b011111, 1'b0, 32'h0,   2'd1, 1'b0};
      tbl[8]  = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd1, 1'b1};
      tbl[9]  = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd0, 1'b0};
      tbl[10] = '{4'b0000, 1'b1, 32'h100, 6'b000000, 1'b1, 32'h100, 2'd0, 1'b0};
      tbl[11] = '{4'b0001, 1'b0, 32'h0,   6'b000011, 1'b0, 32'h0,   2'd3, 1'b0};
      tbl[12] = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd1, 1'b0};
      tbl[13] = '{4'b0011, 1'b1, 32'h200, 6'b000000, 1'b1, 32'h200, 2'd0, 1'b0};
      tbl[14] = '{4'b0010, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd3, 1'b0};
      tbl[15] = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd0, 1'b0};
      tbl[16] = '{4'b1000, 1'b1, 32'h300, 6'b011111, 1'b0, 32'h0,   2'd0, 1'b0};
      tbl[17] = '{4'b1000, 1'b1, 32'h999, 6'b011111, 1'b0, 32'h0,   2'd2, 1'b0};
      tbl[18] = '{4'b0100, 1'b0, 32'h0,   6'b001111, 1'b0, 32'h0,   2'd2, 1'b0};
      tbl[19] = '{4'b0010, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h300, 2'd2, 1'b0};
      tbl[20] = '{4'b0100, 1'b1, 32'h400, 6'b001111, 1'b0, 32'h0,   2'd3, 1'b0};
      tbl[21] = '{4'b0100, 1'b0, 32'h0,   6'b001111, 1'b0, 32'h0,   2'd2, 1'b0};
      tbl[22] = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b1, 32'h400, 2'd2, 1'b0};
      tbl[23] = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd3, 1'b0};
      tbl[24] = '{4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0,   2'd0, 1'b0};

      // Reset with live requests: outputs must stay forced low.
      rst = 1'b0;
      drive(4'b1111, 1'b1, 32'hDEAD_BEEF);
      repeat (3) @(negedge clk);
      #1;
      chk("reset_stall", {26'd0, stall}, 32'd0);
      chk("reset_flush", {31'd0, flush}, 32'd0);
      chk("reset_new_pc", new_pc, 32'd0);
      chk("reset_state", {30'd0, ctrl_state}, 32'd0);
      chk("reset_timeout", {31'd0, stall_timeout}, 32'd0);

      @(negedge clk);
      rst = 1'b1;
      drive(4'b0000, 1'b0, 32'h0);

      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         drive(tbl[i].req, tbl[i].mis, tbl[i].pc);
         #1;
         chk($sformatf("row%0d_stall", i), {26'd0, stall}, {26'd0, tbl[i].st});
         chk($sformatf("row%0d_flush", i), {31'd0, flush}, {31'd0, tbl[i].fl});
         chk($sformatf("row%0d_new_pc", i), new_pc, tbl[i].npc);
         chk($sformatf("row%0d_state", i), {30'd0, ctrl_state}, {30'd0, tbl[i].cs});
         chk($sformatf("row%0d_timeout", i), {31'd0, stall_timeout}, {31'd0, tbl[i].to});
      end

      // Watchdog: EX held for 10 cycles, single pulse in the 5th.
      pulses = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         drive(4'b0100, 1'b0, 32'h0);
         #1;
         if (stall_timeout === 1'b1) pulses++;
         chk($sformatf("wd_cycle%0d", k), {31'd0, stall_timeout}, (k == 5) ? 32'd1 : 32'd0);
      end
      chk("wd_pulse_count", pulses, 32'd1);
      @(negedge clk);
      drive(4'b0000, 1'b0, 32'h0);
      #1;
      chk("wd_release_timeout", {31'd0, stall_timeout}, 32'd0);
      chk("wd_release_state", {30'd0, ctrl_state}, 32'd1);
      // Counter must restart from zero: a fresh 3-cycle stall gives no pulse.
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         drive((k <= 3) ? 4'b1000 : 4'b0000, 1'b0, 32'h0);
         #1;
         chk($sformatf("wd_rearm%0d", k), {31'd0, stall_timeout}, 32'd0);
      end

      // Async reset while a flush is pending.
      @(negedge clk);
      drive(4'b1000, 1'b1, 32'h500);
      @(negedge clk);
      drive(4'b1000, 1'b0, 32'h0);
      #1;
      chk("ar_pend_state", {30'd0, ctrl_state}, 32'd2);
      chk("ar_pend_stall", {26'd0, stall}, 32'h1F);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_stall", {26'd0, stall}, 32'd0);
      chk("ar_flush", {31'd0, flush}, 32'd0);
      chk("ar_state", {30'd0, ctrl_state}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      drive(4'b0000, 1'b0, 32'h0);
      #1;
      chk("ar_post_state", {30'd0, ctrl_state}, 32'd0);
      chk("ar_post_flush", {31'd0, flush}, 32'd0);
      chk("ar_post_new_pc", new_pc, 32'd0);
      chk("ar_post_timeout", {31'd0, stall_timeout}, 32'd0);
      @(negedge clk);
      #1;
      chk("ar_post2_flush", {31'd0, flush}, 32'd0);
      chk("ar_post2_state", {30'd0, ctrl_state}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
